// File: rtl/la_trigger_seq_if.sv
// la_trigger_seq_if: iomem-style request/response bus between the trigger sequencer and the LA controller
interface la_trigger_seq_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0] wstrb;
  logic valid;
  logic ready;
  modport master(output addr, valid, wstrb, wdata, input rdata, ready);
  modport slave(input addr, valid, wstrb, wdata, output rdata, ready);
endinterface

// File: rtl/la_trigger_seq.sv
// la_trigger_seq: polls one LA input word and strobes LA_SAMPLE on masked pattern hits
module la_trigger_seq #(
  parameter logic [31:0] BASE_ADR = 32'h2200_0000,
  parameter logic [7:0] LA_DATA_0 = 8'h00,
  parameter logic [7:0] LA_SAMPLE = 8'h30,
  parameter int PERIOD_W = 16,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic resetn,
  input logic start,
  input logic abort,
  input logic [1:0] trig_word_sel,
  input logic [31:0] trig_mask,
  input logic [31:0] trig_value,
  input logic [PERIOD_W-1:0] poll_period,
  input logic [CNT_W-1:0] sample_count,
  la_trigger_seq_if.master iomem,
  output logic busy,
  output logic done,
  output logic error,
  output logic [CNT_W-1:0] hit_count,
  output logic [31:0] last_word
);
  localparam logic [1:0] IDLE = 2'd0, POLL = 2'd1, WAIT = 2'd2, SAMPLE = 2'd3;
  logic [1:0] state, sel;
  logic [31:0] mask, value, addr;
  logic [PERIOD_W-1:0] period, timer;
  logic [CNT_W-1:0] count, hit_nxt;
  logic [3:0] to, wstrb;
  logic [7:0] poll_off;
  logic valid, match;
  assign iomem.addr = addr;
  assign iomem.valid = valid;
  assign iomem.wstrb = wstrb;
  assign iomem.wdata = '0;
  always_comb begin
    hit_nxt = hit_count + 1'b1;
    poll_off = LA_DATA_0 + {4'd0, (state == IDLE ? trig_word_sel : sel), 2'd0};
    match = ((iomem.rdata ^ value) & mask) == '0;
  end
  // Priority: abort, then bus completion, then timeout, then per-state progress.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      hit_count <= '0;
      last_word <= '0;
      valid <= 1'b0;
      addr <= '0;
      wstrb <= '0;
      to <= '0;
      timer <= '0;
      sel <= '0;
      mask <= '0;
      value <= '0;
      period <= '0;
      count <= '0;
    end else begin
      done <= 1'b0;
      if (busy && abort) begin
        state <= IDLE;
        busy <= 1'b0;
        valid <= 1'b0;
      end else if (valid && iomem.ready) begin
        valid <= 1'b0;
        if (state == POLL) begin
          last_word <= iomem.rdata;
          state <= match ? SAMPLE : WAIT;
          timer <= period;
        end else if (hit_nxt == count) begin
          hit_count <= hit_nxt;
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          hit_count <= hit_nxt;
          state <= WAIT;
          timer <= period;
        end
      end else if (valid) begin
        to <= to + 1'b1;
        if (to == 4'd14) begin
          valid <= 1'b0;
          error <= 1'b1;
          done <= 1'b1;
          state <= IDLE;
          busy <= 1'b0;
        end
      end else if (state == IDLE) begin
        if (start && sample_count == '0) done <= 1'b1;
        else if (start) begin
          sel <= trig_word_sel;
          mask <= trig_mask;
          value <= trig_value;
          period <= poll_period;
          count <= sample_count;
          hit_count <= '0;
          error <= 1'b0;
          state <= POLL;
          busy <= 1'b1;
          valid <= 1'b1;
          addr <= {BASE_ADR[31:8], poll_off};
          wstrb <= 4'h0;
          to <= '0;
        end
      end else if (state == WAIT) begin
        // Leaving at timer<=1 keeps period 0 and 1 both at one idle cycle.
        timer <= timer - 1'b1;
        if (timer[PERIOD_W-1:1] == '0) begin
          state <= POLL;
          valid <= 1'b1;
          addr <= {BASE_ADR[31:8], poll_off};
          wstrb <= 4'h0;
          to <= '0;
        end
      end else if (state == SAMPLE) begin
        valid <= 1'b1;
        addr <= {BASE_ADR[31:8], LA_SAMPLE};
        wstrb <= 4'hF;
        to <= '0;
      end
    end
endmodule

// File: doc/la_trigger_seq.md
Name: la_trigger_seq

Overview:
- Autonomous bus master for the logic-analyzer controller's iomem port. Polls one LA input word and compares it against a masked trigger pattern.
- On each match, writes the LA_SAMPLE register to capture all enabled inputs simultaneously, until a programmed number of hits is reached.
- Sits between a configuration source (housekeeping/CSR block) and the LA controller. Frees the CPU from tight polling loops.

Parameters:
- BASE_ADR, 32'h2200_0000, LA controller base; addr[31:8] driven from BASE_ADR[31:8]
- LA_DATA_0, 8'h00, offset of LA data word 0; word n at LA_DATA_0 + 4*n
- LA_SAMPLE, 8'h30, offset of sample-strobe register
- PERIOD_W, 16, width of poll/holdoff period
- CNT_W, 8, width of hit counters

Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- start  in  1  begin sequence (level, honoured only in IDLE)
- abort  in  1  cancel sequence
- trig_word_sel  in  2  LA input word polled (0..3)
- trig_mask  in  32  compare mask
- trig_value  in  32  compare value
- poll_period  in  PERIOD_W  idle cycles between bus accesses
- sample_count  in  CNT_W  hits to capture before finishing
- iomem_addr  out  32  bus address
- iomem_valid  out  1  bus request
- iomem_wstrb  out  4  byte write strobes (0 = read)
- iomem_wdata  out  32  write data
- iomem_rdata  in  32  read data
- iomem_ready  in  1  one-cycle completion from LA controller
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at sequence end
- error  out  1  sticky bus-timeout flag
- hit_count  out  CNT_W  hits captured this sequence
- last_word  out  32  most recent polled word

Behaviour:
- Reset (resetn low, async): state IDLE; all outputs 0.
- All outputs registered.
- Config capture: mask, value, sel, period and count are latched on the start edge. Input changes mid-sequence have no effect.
- States: IDLE, POLL, WAIT, SAMPLE.
- IDLE, start=1:
  - sample_count==0: done pulses next cycle; stay IDLE.
  - Otherwise: clear hit_count and error; enter POLL.
  - start in any other state is ignored.
- POLL:
  - Drive iomem_valid=1, wstrb=0, addr={BASE_ADR[31:8], LA_DATA_0+4*sel}.
  - On the edge where iomem_ready=1: last_word<=rdata; valid<=0.
  - If (rdata & mask)==(value & mask), go to SAMPLE; else go to WAIT with timer<=poll_period.
- WAIT:
  - Timer decrements each cycle; at 0, go to POLL.
  - poll_period=0 gives exactly one WAIT cycle, so valid is low for ≥1 cycle between requests.
- SAMPLE:
  - Drive valid=1, wstrb=4'hF, wdata=0, addr={BASE_ADR[31:8], LA_SAMPLE}.
  - On ready: valid<=0; hit_count++.
  - If the new hit_count==sample_count: done pulse, go to IDLE. Else go to WAIT (holdoff=poll_period).
- Handshake:
  - valid rises only from a non-bus state, is held until ready, and drops on the same edge ready is sampled high.
  - This means valid is never high in the cycle after ready, so no double transaction.
  - addr/wstrb/wdata are stable while valid=1.
- Timeout:
  - A 4-bit counter counts cycles with valid=1 and ready=0.
  - Reaching 15: valid<=0, error<=1, done pulse, go to IDLE. hit_count is retained.
- abort=1 in any non-IDLE state:
  - Next edge: IDLE, valid=0, no done pulse, hit_count retained.
  - abort has priority over ready, timeout and start in the same cycle.
- ready arriving in the same cycle as a timeout: ready wins (transaction completes).
- hit_count never wraps: it stops at sample_count ≤ 2^CNT_W−1.

Test Plan:
- Match on first poll: sel=1, mask=FF, value=5A, count=1, period=3; LA in[39:32]=5A -> POLL addr 22000004, then SAMPLE write to 22000030 wstrb F; done pulse; hit_count=1; last_word[7:0]=5A.
- No match, then match: value=0F, inputs 00 for three polls, then 0F; period=4 -> exactly 4 WAIT cycles between polls; 4th poll triggers sample; valid low ≥1 cycle after each ready.
- Multi-hit: count=3, input constantly matching, period=0 -> three SAMPLE writes, hit_count 1,2,3; single done after third; busy falls with done.
- Bus timeout: hold ready=0 in POLL -> valid drops after 15 cycles; error=1; done pulse; next start clears error.
- Abort mid-WAIT and during a pending SAMPLE with ready asserted the same cycle -> IDLE next edge, no done, hit_count unchanged; resetn pulsed low mid-POLL -> all outputs 0 immediately (async).
- count=0 start -> done next cycle, no bus traffic; start asserted while busy is ignored.
